// File: rtl/avmm_arb_pkg.sv
// Shared defaults, ID-width helper and arbiter state encoding
// for the Avalon-MM SDRAM arbiter.
package avmm_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = 4;
    localparam int CNT_W      = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avmm_arb_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads.
// Pointers carry one extra wrap bit to tell full from empty.
module avmm_arb_id_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wp;
    logic [PW:0]      rp;

    assign empty = (wp == rp);
    assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign head  = mem[rp[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + 1'b1;
            if (pop && !empty)
                rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wp[PW-1:0]] <= din;
    end

endmodule

// File: rtl/avmm_sdram_arbiter.sv
// Round-robin Avalon-MM arbiter in front of one SDRAM slave.
// Define AVMM_ARB_PERF_CNT_EN to build the per-master transfer counters.
module avmm_sdram_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_PENDING = 8
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]             s_address,
    output logic                          s_read,
    output logic                          s_write,
    output logic [DATA_W-1:0]             s_writedata,
    output logic [DATA_W/8-1:0]           s_byteenable,
    input  logic [DATA_W-1:0]             s_readdata,
    input  logic                          s_waitrequest,
    input  logic                          s_readdatavalid,
    output logic                          err_unexpected_rdv,
    output logic [NUM_MASTERS*CNT_W-1:0]  perf_xfer_cnt
);

    localparam int BE_W = DATA_W / 8;
    localparam int ID_W = id_w(NUM_MASTERS);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_MASTERS - 1);

    // First requester strictly after base, wrapping; base itself comes last.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_MASTERS-1:0] r,
        input logic [ID_W-1:0]        base
    );
        logic [ID_W-1:0] w;
        int              idx;
        w = base;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = (int'(base) + k) % NUM_MASTERS;
            if (r[idx])
                w = ID_W'(idx);
        end
        return w;
    endfunction

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] others;
    logic                   gv;
    logic                   rd_g;
    logic                   wr_g;
    logic                   blocked;
    logic                   accept;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ID_W-1:0]        head_id;

    assign req    = m_read | m_write;
    assign others = req & ~(NUM_MASTERS'(1) << grant_id_q);
    assign gv     = (state_q == GRANT);
    assign rd_g   = m_read[grant_id_q];
    assign wr_g   = m_write[grant_id_q];

    // A read with no free ID slot stalls; writes never do.
    assign blocked = gv & rd_g & fifo_full;
    assign s_read  = gv & rd_g & ~fifo_full;
    assign s_write = gv & wr_g & ~rd_g;
    assign accept  = (s_read | s_write) & ~s_waitrequest;

    assign s_address    = m_address[int'(grant_id_q)*ADDR_W +: ADDR_W];
    assign s_writedata  = m_writedata[int'(grant_id_q)*DATA_W +: DATA_W];
    assign s_byteenable = m_byteenable[int'(grant_id_q)*BE_W +: BE_W];

    always_comb begin
        m_waitrequest = '1;
        if (gv)
            m_waitrequest[grant_id_q] = blocked | s_waitrequest;
    end

    always_comb begin
        m_readdatavalid = '0;
        if (s_readdatavalid && !fifo_empty)
            m_readdatavalid[head_id] = 1'b1;
    end

    assign m_readdata = reset_reset ? '0 : s_readdata;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    grant_id_d = rr_pick(req, last_id_q);
                end
            end
            GRANT: begin
                if (accept) begin
                    last_id_d = grant_id_q;
                    if (|req)
                        grant_id_d = rr_pick(req, grant_id_q);
                    else
                        state_d = IDLE;
                end else if (!req[grant_id_q] || (blocked && |others)) begin
                    // Grantee left, or is stuck on a full FIFO while others wait.
                    if (|others)
                        grant_id_d = rr_pick(others, grant_id_q);
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_id_q  <= LAST_ID;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
        end
    end

    avmm_arb_id_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (accept & s_read),
        .din   (grant_id_q),
        .pop   (s_readdatavalid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_id)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            err_unexpected_rdv <= 1'b0;
        else if (s_readdatavalid && fifo_empty)
            err_unexpected_rdv <= 1'b1;
    end

`ifdef AVMM_ARB_PERF_CNT_EN
    logic [NUM_MASTERS-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            cnt_q <= '0;
        else if (accept && cnt_q[grant_id_q] != '1)
            cnt_q[grant_id_q] <= cnt_q[grant_id_q] + 1'b1;
    end

    assign perf_xfer_cnt = cnt_q;
`else
    assign perf_xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_avmm_sdram_arbiter.sv
// Bench for avmm_sdram_arbiter: directed scenarios plus random
// traffic scored against a transaction-level model.
module tb_avmm_sdram_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MP = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] m_address;
    logic [N-1:0]    m_read;
    logic [N-1:0]    m_write;
    logic [N*DW-1:0] m_writedata;
    logic [N*BW-1:0] m_byteenable;
    logic [N-1:0]    m_waitrequest;
    logic [DW-1:0]   m_readdata;
    logic [N-1:0]    m_readdatavalid;
    logic [AW-1:0]   s_address;
    logic            s_read;
    logic            s_write;
    logic [DW-1:0]   s_writedata;
    logic [BW-1:0]   s_byteenable;
    logic [DW-1:0]   s_readdata;
    logic            s_waitrequest;
    logic            s_readdatavalid;
    logic            err_unexpected_rdv;
    logic [N*16-1:0] perf_xfer_cnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int rr_last;

    always #5 clk = ~clk;

    avmm_sdram_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_PENDING (MP)
    ) dut (
        .clk_clk            (clk),
        .reset_reset        (rst),
        .m_address          (m_address),
        .m_read             (m_read),
        .m_write            (m_write),
        .m_writedata        (m_writedata),
        .m_byteenable       (m_byteenable),
        .m_waitrequest      (m_waitrequest),
        .m_readdata         (m_readdata),
        .m_readdatavalid    (m_readdatavalid),
        .s_address          (s_address),
        .s_read             (s_read),
        .s_write            (s_write),
        .s_writedata        (s_writedata),
        .s_byteenable       (s_byteenable),
        .s_readdata         (s_readdata),
        .s_waitrequest      (s_waitrequest),
        .s_readdatavalid    (s_readdatavalid),
        .err_unexpected_rdv (err_unexpected_rdv),
        .perf_xfer_cnt      (perf_xfer_cnt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m_address       = '0;
        m_read          = '0;
        m_write         = '0;
        m_writedata     = '0;
        m_byteenable    = '0;
        s_readdata      = '0;
        s_waitrequest   = 1'b0;
        s_readdatavalid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        exp_q.delete();
        rr_last = N - 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_master(input int i, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [BW-1:0] be);
        m_read[i]                = rd;
        m_write[i]               = wr;
        m_address[i*AW +: AW]    = a;
        m_writedata[i*DW +: DW]  = d;
        m_byteenable[i*BW +: BW] = be;
    endtask

    // Waits (bounded) until master m's transfer is accepted at the slave.
    task automatic wait_accept(input int m, output bit ok,
                               output logic [AW-1:0] sa);
        ok = 0;
        sa = '0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!m_waitrequest[m] && (s_read || s_write) && !s_waitrequest) begin
                ok = 1;
                sa = s_address;
                if (s_read)
                    exp_q.push_back(m);
                rr_last = m;
            end
            step();
            if (ok)
                break;
        end
    endtask

    task automatic pulse_rdv(input logic [DW-1:0] d, output logic [N-1:0] v,
                             output logic [DW-1:0] od);
        s_readdatavalid = 1'b1;
        s_readdata      = d;
        #1;
        v  = m_readdatavalid;
        od = m_readdata;
        step();
        s_readdatavalid = 1'b0;
    endtask

    task automatic test_reset;
        rst             = 1'b1;
        m_read          = '1;
        s_readdata      = 32'hCAFE_F00D;
        s_readdatavalid = 1'b1;
        #2;
        checks++;
        if (s_read !== 1'b0 || s_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_sctl got %b%b want 00", s_read, s_write);
        end
        checks++;
        if (m_waitrequest !== 2'b11 || m_readdatavalid !== 2'b00) begin
            errors++;
            $display("FAIL reset_mctl wr %b rdv %b want 11 00",
                     m_waitrequest, m_readdatavalid);
        end
        checks++;
        if (m_readdata !== 32'h0 || err_unexpected_rdv !== 1'b0 ||
            perf_xfer_cnt !== '0) begin
            errors++;
            $display("FAIL reset_misc rd %h err %b cnt %h want 0",
                     m_readdata, err_unexpected_rdv, perf_xfer_cnt);
        end
        do_reset();
    endtask

    task automatic test_single;
        logic [N-1:0]  v;
        logic [DW-1:0] d;
        int            e;
        set_master(0, 1'b1, 1'b0, 32'h100, '0, 4'hF);
        #1;
        checks++;
        if (s_read !== 1'b0 || m_waitrequest !== 2'b11) begin
            errors++;
            $display("FAIL single_arb s_read %b wr %b want 0 11",
                     s_read, m_waitrequest);
        end
        step();
        #1;
        checks++;
        if (s_read !== 1'b1 || s_address !== 32'h100 || m_waitrequest[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_issue s_read %b addr %h wr %b want 1 100 0",
                     s_read, s_address, m_waitrequest[0]);
        end
        exp_q.push_back(0);
        rr_last = 0;
        step();
        m_read[0] = 1'b0;
        step();
        step();
        pulse_rdv(32'hDEAD_BEEF, v, d);
        e = exp_q.pop_front();
        checks++;
        if (v !== 2'(1 << e) || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_ret rdv %b data %h want %b deadbeef",
                     v, d, 2'(1 << e));
        end
    endtask

    task automatic test_round_robin;
        logic [DW-1:0] wd [N];
        int            upd;
        int            w;
        upd = -1;
        for (int i = 0; i < N; i++) begin
            wd[i] = $urandom;
            set_master(i, 1'b0, 1'b1, 32'h200 + i, wd[i], 4'hF);
        end
        #1;
        checks++;
        if (s_write !== 1'b0) begin
            errors++;
            $display("FAIL rr_arb s_write %b want 0", s_write);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            if (upd >= 0) begin
                wd[upd] = $urandom;
                m_writedata[upd*DW +: DW] = wd[upd];
            end
            #1;
            w = (rr_last + 1) % N;
            checks++;
            if (s_write !== 1'b1 || s_waitrequest !== 1'b0 ||
                m_waitrequest !== ~2'(1 << w) || s_writedata !== wd[w]) begin
                errors++;
                $display("FAIL rr_beat%0d wr %b data %h want %b %h",
                         k, m_waitrequest, s_writedata, ~2'(1 << w), wd[w]);
            end
            rr_last = w;
            upd = w;
        end
        step();
        m_write = '0;
    endtask

    task automatic test_interleave;
        bit            ok;
        logic [AW-1:0] sa;
        logic [N-1:0]  v;
        logic [DW-1:0] d;
        int            e;
        set_master(0, 1'b1, 1'b0, 32'h10, '0, 4'hF);
        wait_accept(0, ok, sa);
        checks++;
        if (!ok || sa !== 32'h10) begin
            errors++;
            $display("FAIL il_m0 ok %0d addr %h want 1 10", ok, sa);
        end
        m_read[0] = 1'b0;
        set_master(1, 1'b1, 1'b0, 32'h20, '0, 4'hF);
        wait_accept(1, ok, sa);
        checks++;
        if (!ok || sa !== 32'h20) begin
            errors++;
            $display("FAIL il_m1 ok %0d addr %h want 1 20", ok, sa);
        end
        m_read[1] = 1'b0;
        pulse_rdv(32'hAAAA, v, d);
        e = exp_q.pop_front();
        checks++;
        if (v !== 2'b01 || v !== 2'(1 << e) || d !== 32'hAAAA) begin
            errors++;
            $display("FAIL il_ret0 rdv %b data %h want 01 aaaa", v, d);
        end
        pulse_rdv(32'hBBBB, v, d);
        e = exp_q.pop_front();
        checks++;
        if (v !== 2'b10 || v !== 2'(1 << e) || d !== 32'hBBBB) begin
            errors++;
            $display("FAIL il_ret1 rdv %b data %h want 10 bbbb", v, d);
        end
    endtask

    task automatic test_pending_limit;
        bit            ok;
        logic [AW-1:0] sa;
        logic [N-1:0]  v;
        logic [DW-1:0] d;
        int            e;
        int            nacc;
        nacc = 0;
        for (int k = 0; k < MP; k++) begin
            set_master(0, 1'b1, 1'b0, 32'h1000 + 4 * k, '0, 4'hF);
            wait_accept(0, ok, sa);
            if (ok && sa == 32'h1000 + 4 * k)
                nacc++;
        end
        checks++;
        if (nacc != MP) begin
            errors++;
            $display("FAIL pend_fill accepted %0d want %0d", nacc, MP);
        end
        set_master(0, 1'b1, 1'b0, 32'h2000, '0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (m_waitrequest[0] !== 1'b1 || s_read !== 1'b0) begin
                errors++;
                $display("FAIL pend_hold%0d wr %b s_read %b want 1 0",
                         k, m_waitrequest[0], s_read);
            end
            step();
        end
        set_master(1, 1'b0, 1'b1, 32'h3000, 32'h1234_5678, 4'h3);
        wait_accept(1, ok, sa);
        checks++;
        if (!ok || sa !== 32'h3000) begin
            errors++;
            $display("FAIL pend_write ok %0d addr %h want 1 3000", ok, sa);
        end
        m_write[1] = 1'b0;
        step();
        #1;
        checks++;
        if (m_waitrequest[0] !== 1'b1 || s_read !== 1'b0) begin
            errors++;
            $display("FAIL pend_rehold wr %b s_read %b want 1 0",
                     m_waitrequest[0], s_read);
        end
        step();
        pulse_rdv(32'h0, v, d);
        e = exp_q.pop_front();
        checks++;
        if (v !== 2'(1 << e)) begin
            errors++;
            $display("FAIL pend_pop rdv %b want %b", v, 2'(1 << e));
        end
        #1;
        checks++;
        if (m_waitrequest[0] !== 1'b0 || s_read !== 1'b1 || s_address !== 32'h2000) begin
            errors++;
            $display("FAIL pend_ninth wr %b s_read %b addr %h want 0 1 2000",
                     m_waitrequest[0], s_read, s_address);
        end
        exp_q.push_back(0);
        rr_last = 0;
        step();
        m_read[0] = 1'b0;
        nacc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pulse_rdv($urandom, v, d);
            if (v === 2'(1 << e))
                nacc++;
        end
        checks++;
        if (nacc != MP) begin
            errors++;
            $display("FAIL pend_drain routed %0d want %0d", nacc, MP);
        end
    endtask

    task automatic test_unexpected;
        logic [N-1:0]  v;
        logic [DW-1:0] d;
        pulse_rdv(32'h55, v, d);
        checks++;
        if (v !== 2'b00) begin
            errors++;
            $display("FAIL unexp_rdv got %b want 00", v);
        end
        #1;
        checks++;
        if (err_unexpected_rdv !== 1'b1) begin
            errors++;
            $display("FAIL unexp_set got %b want 1", err_unexpected_rdv);
        end
        repeat (3) step();
        checks++;
        if (err_unexpected_rdv !== 1'b1) begin
            errors++;
            $display("FAIL unexp_sticky got %b want 1", err_unexpected_rdv);
        end
    endtask

    task automatic test_reset_mid;
        bit            ok;
        logic [AW-1:0] sa;
        logic [N-1:0]  v;
        logic [DW-1:0] d;
        int            nacc;
        int            e;
        nacc = 0;
        for (int k = 0; k < 3; k++) begin
            set_master(0, 1'b1, 1'b0, 32'h500 + k, '0, 4'hF);
            wait_accept(0, ok, sa);
            if (ok)
                nacc++;
        end
        checks++;
        if (nacc != 3) begin
            errors++;
            $display("FAIL rmid_issue accepted %0d want 3", nacc);
        end
        s_waitrequest   = 1'b1;
        s_readdatavalid = 1'b1;
        s_readdata      = 32'h1357_9BDF;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (s_read !== 1'b0 || s_write !== 1'b0 || m_waitrequest !== 2'b11 ||
            m_readdatavalid !== 2'b00 || m_readdata !== 32'h0 ||
            err_unexpected_rdv !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async rd %b wr %b mw %b rdv %b d %h err %b want 0 0 11 00 0 0",
                     s_read, s_write, m_waitrequest, m_readdatavalid,
                     m_readdata, err_unexpected_rdv);
        end
        do_reset();
        pulse_rdv(32'h77, v, d);
        #1;
        checks++;
        if (v !== 2'b00 || err_unexpected_rdv !== 1'b1) begin
            errors++;
            $display("FAIL rmid_stale rdv %b err %b want 00 1",
                     v, err_unexpected_rdv);
        end
        set_master(1, 1'b1, 1'b0, 32'h40, '0, 4'hF);
        #1;
        checks++;
        if (m_waitrequest !== 2'b11) begin
            errors++;
            $display("FAIL rmid_arb wr %b want 11", m_waitrequest);
        end
        step();
        #1;
        checks++;
        if (m_waitrequest !== 2'b01 || s_read !== 1'b1 || s_address !== 32'h40) begin
            errors++;
            $display("FAIL rmid_m1 wr %b s_read %b addr %h want 01 1 40",
                     m_waitrequest, s_read, s_address);
        end
        exp_q.push_back(1);
        step();
        m_read[1] = 1'b0;
        pulse_rdv(32'h4242, v, d);
        e = exp_q.pop_front();
        checks++;
        if (v !== 2'(1 << e) || d !== 32'h4242) begin
            errors++;
            $display("FAIL rmid_ret rdv %b data %h want %b 4242",
                     v, d, 2'(1 << e));
        end
    endtask

    task automatic test_random;
        bit            busy [N];
        bit            t_rd [N];
        logic [AW-1:0] t_addr [N];
        logic [DW-1:0] t_data [N];
        logic [BW-1:0] t_be [N];
        int            cnt [N];
        int            bad_rdv;
        int            bad_acc;
        int            nacc;
        bit            rdv_now;
        logic [DW-1:0] rdata;
        logic [N-1:0]  v;
        logic [DW-1:0] d;
        int            m;
        int            e;
        logic [15:0]   want;
        do_reset();
        bad_rdv = 0;
        bad_acc = 0;
        nacc    = 0;
        for (int i = 0; i < N; i++) begin
            busy[i] = 0;
            cnt[i]  = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!busy[i] && $urandom_range(0, 2) == 0) begin
                    busy[i]   = 1;
                    t_rd[i]   = 1'($urandom_range(0, 1));
                    t_addr[i] = $urandom;
                    t_data[i] = $urandom;
                    t_be[i]   = 4'($urandom);
                end
                set_master(i, busy[i] && t_rd[i], busy[i] && !t_rd[i],
                           t_addr[i], t_data[i], t_be[i]);
            end
            s_waitrequest   = ($urandom_range(0, 3) == 0);
            rdv_now         = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
            rdata           = $urandom;
            s_readdatavalid = rdv_now;
            s_readdata      = rdata;
            #1;
            if (rdv_now) begin
                e = exp_q.pop_front();
                if (m_readdatavalid !== 2'(1 << e) || m_readdata !== rdata)
                    bad_rdv++;
            end else if (m_readdatavalid !== 2'b00) begin
                bad_rdv++;
            end
            if ((s_read || s_write) && !s_waitrequest) begin
                nacc++;
                m = -1;
                for (int i = 0; i < N; i++)
                    if (!m_waitrequest[i])
                        m = i;
                if (m < 0 || $countones(~m_waitrequest) != 1 || !busy[m] ||
                    s_address !== t_addr[m]) begin
                    bad_acc++;
                end else begin
                    if (t_rd[m]) begin
                        if (!(s_read && !s_write))
                            bad_acc++;
                        exp_q.push_back(m);
                    end else if (!(s_write && !s_read) ||
                                 s_writedata !== t_data[m] ||
                                 s_byteenable !== t_be[m]) begin
                        bad_acc++;
                    end
                    busy[m] = 0;
                    cnt[m]++;
                end
            end
            step();
        end
        s_readdatavalid = 1'b0;
        m_read  = '0;
        m_write = '0;
        step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pulse_rdv(32'h0, v, d);
            if (v !== 2'(1 << e))
                bad_rdv++;
        end
        checks++;
        if (nacc < 50) begin
            errors++;
            $display("FAIL rand_activity accepts %0d want >= 50", nacc);
        end
        checks++;
        if (bad_acc != 0) begin
            errors++;
            $display("FAIL rand_accept bad %0d want 0", bad_acc);
        end
        checks++;
        if (bad_rdv != 0) begin
            errors++;
            $display("FAIL rand_route bad %0d want 0", bad_rdv);
        end
        checks++;
        if (err_unexpected_rdv !== 1'b0) begin
            errors++;
            $display("FAIL rand_err got %b want 0", err_unexpected_rdv);
        end
        for (int i = 0; i < N; i++) begin
`ifdef AVMM_ARB_PERF_CNT_EN
            want = (cnt[i] > 65535) ? 16'hFFFF : 16'(cnt[i]);
`else
            want = 16'h0;
`endif
            checks++;
            if (perf_xfer_cnt[i*16 +: 16] !== want) begin
                errors++;
                $display("FAIL rand_perf%0d got %0d want %0d",
                         i, perf_xfer_cnt[i*16 +: 16], want);
            end
        end
    endtask

    initial begin
        clear_inputs();
        rr_last = N - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_interleave();
        test_pending_limit();
        test_unexpected();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
